gate_sweep_engine: RTL and testbench

- Parametrised, clocked truth-table sweep engine for an N-input logic gate with a selectable operation.
- On start, walks every input vector 0 to 2^N_IN-1 and holds each one for HOLD cycles.
- Drives the vector and a registered gate result, and strobes a sample point on each vector.
- Serves as the reusable stimulus/golden source for gate-level blocks in the assignment set.

---
 rtl/gate_sweep_pkg.sv | 27 ++
 rtl/gate_sweep_engine_if.sv | 51 +++++
 rtl/gate_eval.sv | 36 +++
 rtl/gate_sweep_engine.sv | 144 ++++++++++++++
 tb/tb_gate_sweep_engine.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and helpers for the gate sweep engine.
// Op encoding, FSM state encoding and the hold-counter width helper.
package gate_sweep_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width that holds 0..hold-1; never narrower than one bit.
  function automatic int hold_cnt_width(input int hold);
    return (hold < 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/gate_sweep_engine_if.sv
// gate_sweep_engine_if: control and result bundle of the gate sweep engine.
// The dut_out / err_cnt / mismatch fields exist only when GATE_SWEEP_CHECK_EN
// is defined. master = stimulus/consumer side, slave = the engine.
interface gate_sweep_engine_if
  import gate_sweep_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);

  logic            i_start;
  logic            i_abort;
  logic [OP_W-1:0] i_op;
  logic [N_IN-1:0] o_vec;
  logic            o_gate_out;
  logic            o_strobe;
  logic            o_busy;
  logic            o_done;

`ifdef GATE_SWEEP_CHECK_EN
  logic             i_dut_out;
  logic [ERR_W-1:0] o_err_cnt;
  logic             o_mismatch;

  modport master (
    output i_start, i_abort, i_op, i_dut_out,
    input  o_vec, o_gate_out, o_strobe, o_busy, o_done, o_err_cnt, o_mismatch
  );

  modport slave (
    input  i_start, i_abort, i_op, i_dut_out,
    output o_vec, o_gate_out, o_strobe, o_busy, o_done, o_err_cnt, o_mismatch
  );
`else
  modport master (
    output i_start, i_abort, i_op,
    input  o_vec, o_gate_out, o_strobe, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_op,
    output o_vec, o_gate_out, o_strobe, o_busy, o_done
  );
`endif

  // A zero-width error counter is meaningless even when the checker is off.
  if (ERR_W < 1) begin : g_bad_err_w
    $error("gate_sweep_engine_if: ERR_W must be at least 1");
  end

endinterface

// File: rtl/gate_eval.sv
// gate_eval: combinational N_IN-input gate evaluator with selectable op.
// Reserved op codes (6, 7) evaluate to 0. With N_IN=1 the reductions
// collapse to a buffer (AND/OR/XOR) or an inverter (NAND/NOR/XNOR).
module gate_eval
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] i_vec,
  input  logic [OP_W-1:0] i_op,
  output logic            o_result
);

  logic w_and;
  logic w_or;
  logic w_xor;

  assign w_and = &i_vec;
  assign w_or  = |i_vec;
  assign w_xor = ^i_vec;

  // Select the reduction named by the op code.
  always_comb begin
    o_result = 1'b0;
    case (i_op)
      OP_AND:  o_result = w_and;
      OP_OR:   o_result = w_or;
      OP_XOR:  o_result = w_xor;
      OP_NAND: o_result = ~w_and;
      OP_NOR:  o_result = ~w_or;
      OP_XNOR: o_result = ~w_xor;
      default: o_result = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_engine.sv
// gate_sweep_engine: walks every N_IN-bit input vector, holding each for HOLD
// cycles, and drives the vector plus its registered gate result. strobe marks
// the last hold cycle of each vector, done pulses once after the final vector.
// Optional on-the-fly checker against an external dut_out: GATE_SWEEP_CHECK_EN.
module gate_sweep_engine
  import gate_sweep_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int HOLD  = 10,
  parameter int ERR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  gate_sweep_engine_if.slave bus
);

  localparam int              CNT_W    = hold_cnt_width(HOLD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_MAX  = {N_IN{1'b1}};

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  // HOLD >= 2 is what lets the one-cycle-late gate result line up with vec
  // by the time strobe fires.
  if (HOLD < 2) begin : g_bad_hold
    $error("gate_sweep_engine: HOLD must be at least 2");
  end
  if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_n_in
    $error("gate_sweep_engine: N_IN must be in 1..8");
  end
  if (ERR_W < 1) begin : g_bad_err_w
    $error("gate_sweep_engine: ERR_W must be at least 1");
  end

  logic [1:0]      r_state;
  logic [OP_W-1:0] r_op_q;
  logic [N_IN-1:0] r_vec;
  logic [CNT_W-1:0] r_hold_cnt;
  logic            r_gate_out;

  logic w_run;
  logic w_last;
  logic w_accept;
  logic w_eval;

  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_hold_cnt == LAST_CNT);
  // abort outranks start when both arrive in IDLE.
  assign w_accept = (r_state == S_IDLE) && bus.i_start && !bus.i_abort;

  gate_eval #(
    .N_IN (N_IN)
  ) u_gate_eval (
    .i_vec    (r_vec),
    .i_op     (r_op_q),
    .o_result (w_eval)
  );

  // Sweep FSM: IDLE -> RUN (vector walk) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_op_q     <= '0;
      r_vec      <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_RUN;
            r_op_q     <= bus.i_op;
            r_vec      <= '0;
            r_hold_cnt <= '0;
          end
        end
        S_RUN: begin
          // abort wins over both the vector advance and the entry to DONE;
          // vec is left where it was so the caller can see how far it got.
          if (bus.i_abort) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
          end else if (w_last) begin
            r_hold_cnt <= '0;
            if (r_vec == VEC_MAX) begin
              r_state <= S_DONE;
            end else begin
              r_vec <= r_vec + N_IN'(1);
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register the gate result; it trails vec by one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_gate_out <= 1'b0;
    end else begin
      r_gate_out <= w_eval;
    end
  end

  assign bus.o_vec      = r_vec;
  assign bus.o_gate_out = r_gate_out;
  assign bus.o_strobe   = w_last;
  assign bus.o_busy     = w_run;
  assign bus.o_done     = (r_state == S_DONE);

`ifdef GATE_SWEEP_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [ERR_W-1:0] r_err_cnt;
  logic             w_mismatch;

  // Only the strobe cycle is a valid sample point for the block under test.
  assign w_mismatch = w_last && (bus.i_dut_out != r_gate_out);

  // Saturating mismatch counter; cleared when a new sweep is accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept) begin
      r_err_cnt <= '0;
    end else if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign bus.o_err_cnt  = r_err_cnt;
  assign bus.o_mismatch = w_mismatch;
`endif

endmodule

// File: tb/tb_gate_sweep_engine.sv
// tb_gate_sweep_engine: two engine instances (N_IN=2/HOLD=10 and
// N_IN=3/HOLD=2) checked every cycle against a position-based model,
// plus a table of full sweeps and hand-written abort/reset sequences.
module tb_gate_sweep_engine;

  localparam int NA = 2;
  localparam int HA = 10;
  localparam int EA = 8;
  localparam int NB = 3;
  localparam int HB = 2;
  localparam int EB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       drv_start [2];
  logic       drv_abort [2];
  logic [2:0] drv_op    [2];
  int         dut_mode  [2];

  logic [7:0] act_vec    [2];
  logic       act_gate   [2];
  logic       act_strobe [2];
  logic       act_busy   [2];
  logic       act_done   [2];
  logic       act_mis    [2];
  int         act_err    [2];

  gate_sweep_engine_if #(.N_IN(NA), .ERR_W(EA)) bus_a ();
  gate_sweep_engine_if #(.N_IN(NB), .ERR_W(EB)) bus_b ();

  gate_sweep_engine #(.N_IN(NA), .HOLD(HA), .ERR_W(EA)) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  gate_sweep_engine #(.N_IN(NB), .HOLD(HB), .ERR_W(EB)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  assign bus_a.i_start = drv_start[0];
  assign bus_a.i_abort = drv_abort[0];
  assign bus_a.i_op    = drv_op[0];
  assign bus_b.i_start = drv_start[1];
  assign bus_b.i_abort = drv_abort[1];
  assign bus_b.i_op    = drv_op[1];

  assign act_vec[0]    = 8'(bus_a.o_vec);
  assign act_gate[0]   = bus_a.o_gate_out;
  assign act_strobe[0] = bus_a.o_strobe;
  assign act_busy[0]   = bus_a.o_busy;
  assign act_done[0]   = bus_a.o_done;
  assign act_vec[1]    = 8'(bus_b.o_vec);
  assign act_gate[1]   = bus_b.o_gate_out;
  assign act_strobe[1] = bus_b.o_strobe;
  assign act_busy[1]   = bus_b.o_busy;
  assign act_done[1]   = bus_b.o_done;

`ifdef GATE_SWEEP_CHECK_EN
  // mode 0: dut_out tied high; mode 1: dut_out is the inverse of gate_out.
  assign bus_a.i_dut_out = (dut_mode[0] == 1) ? ~bus_a.o_gate_out : 1'b1;
  assign bus_b.i_dut_out = (dut_mode[1] == 1) ? ~bus_b.o_gate_out : 1'b1;
  assign act_mis[0] = bus_a.o_mismatch;
  assign act_mis[1] = bus_b.o_mismatch;
  assign act_err[0] = int'(bus_a.o_err_cnt);
  assign act_err[1] = int'(bus_b.o_err_cnt);
`else
  assign act_mis[0] = 1'b0;
  assign act_mis[1] = 1'b0;
  assign act_err[0] = 0;
  assign act_err[1] = 0;
`endif

  // ---------------- reference model ----------------
  // A running sweep is described by its position p (cycles since the
  // accepting edge); vec, strobe and done follow from p by arithmetic.
  int m_n      [2] = '{NA, NB};
  int m_hold   [2] = '{HA, HB};
  int m_errmax [2] = '{(1 << EA) - 1, (1 << EB) - 1};
  bit m_valid = 1'b0;
  bit m_run  [2];
  bit m_dn   [2];
  int m_p    [2];
  int m_vec  [2];
  int m_opq  [2];
  bit m_gate [2];
  int m_err  [2];

  function automatic bit ref_gate(input int n, input int v, input int op);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (op)
      0:       return ones == n;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      3:       return ones != n;
      4:       return ones == 0;
      5:       return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_strobe(input int id);
    return m_run[id] && ((m_p[id] % m_hold[id]) == (m_hold[id] - 1));
  endfunction

  function automatic bit exp_mis(input int id);
    bit dout;
    dout = (dut_mode[id] == 1) ? !m_gate[id] : 1'b1;
    return exp_strobe(id) && (dout != m_gate[id]);
  endfunction

  task automatic model_step();
    for (int id = 0; id < 2; id++) begin
      bit g;
      bit mis;
      int total;
      total = (1 << m_n[id]) * m_hold[id];
      mis   = exp_mis(id);
      if (!rst_n) begin
        m_run[id] = 1'b0; m_dn[id] = 1'b0; m_p[id] = 0; m_vec[id] = 0;
        m_opq[id] = 0; m_gate[id] = 1'b0; m_err[id] = 0;
        m_valid = 1'b1;
      end else begin
        if (mis && (m_err[id] < m_errmax[id])) m_err[id]++;
        g = ref_gate(m_n[id], m_vec[id], m_opq[id]);
        if (m_dn[id]) begin
          m_dn[id] = 1'b0;
        end else if (m_run[id]) begin
          if (drv_abort[id]) begin
            m_run[id] = 1'b0;
          end else if (m_p[id] == total - 1) begin
            m_run[id] = 1'b0;
            m_dn[id]  = 1'b1;
          end else begin
            m_p[id]++;
            m_vec[id] = m_p[id] / m_hold[id];
          end
        end else if (drv_start[id] && !drv_abort[id]) begin
          m_run[id] = 1'b1; m_p[id] = 0; m_vec[id] = 0;
          m_opq[id] = int'(drv_op[id]); m_err[id] = 0;
        end
        m_gate[id] = g;
      end
    end
  endtask

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut=%0d t=%0t actual=%0d required=%0d", name, id, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int id = 0; id < 2; id++) begin
      chk("cyc_vec",    id, int'(act_vec[id]),    m_vec[id]);
      chk("cyc_gate",   id, int'(act_gate[id]),   int'(m_gate[id]));
      chk("cyc_strobe", id, int'(act_strobe[id]), int'(exp_strobe(id)));
      chk("cyc_busy",   id, int'(act_busy[id]),   int'(m_run[id]));
      chk("cyc_done",   id, int'(act_done[id]),   int'(m_dn[id]));
`ifdef GATE_SWEEP_CHECK_EN
      chk("cyc_mismatch", id, int'(act_mis[id]), int'(exp_mis(id)));
      chk("cyc_err_cnt",  id, act_err[id],       m_err[id]);
`endif
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) check_all();
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int         id;
    int         op;
    int         nstb;
    logic [7:0] pat;
    int         lat;
  } sweep_t;

  // Start a sweep, then record gate_out at each strobe until done (bounded).
  task automatic run_sweep(input int id, input int op, output logic [7:0] pat,
                           output int nstb, output int lat, output int nmis);
    int c;
    pat = '0; nstb = 0; lat = -1; nmis = 0;
    @(negedge clk);
    drv_op[id] = 3'(op);
    drv_start[id] = 1'b1;
    @(negedge clk);
    drv_start[id] = 1'b0;
    c = 1;
    while (c < 1000) begin
      if (act_strobe[id]) begin
        if (nstb < 8) pat[nstb] = act_gate[id];
        nstb++;
      end
      if (act_mis[id]) nmis++;
      if (act_done[id]) begin
        lat = c;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    sweep_t     tbl [8];
    logic [7:0] pat;
    int         nstb;
    int         lat;
    int         nmis;
    int         c;
    int         ndone;

    // gate_out sampled at strobes, bit k = k-th vector; latency = 2^N*HOLD+1
    tbl[0] = '{0, 0, 4, 8'h08, 41};  // AND   0,0,0,1
    tbl[1] = '{1, 2, 8, 8'h96, 17};  // XOR3  0,1,1,0,1,0,0,1
    tbl[2] = '{0, 1, 4, 8'h0E, 41};  // OR    0,1,1,1
    tbl[3] = '{0, 4, 4, 8'h01, 41};  // NOR   1,0,0,0
    tbl[4] = '{0, 5, 4, 8'h09, 41};  // XNOR  1,0,0,1
    tbl[5] = '{0, 6, 4, 8'h00, 41};  // reserved
    tbl[6] = '{1, 3, 8, 8'h7F, 17};  // NAND3 1,1,1,1,1,1,1,0
    tbl[7] = '{1, 7, 8, 8'h00, 17};  // reserved

    for (int id = 0; id < 2; id++) begin
      drv_start[id] = 1'b0;
      drv_abort[id] = 1'b0;
      drv_op[id]    = 3'd0;
      dut_mode[id]  = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      chk("reset_vec",    id, int'(act_vec[id]),    0);
      chk("reset_gate",   id, int'(act_gate[id]),   0);
      chk("reset_strobe", id, int'(act_strobe[id]), 0);
      chk("reset_busy",   id, int'(act_busy[id]),   0);
      chk("reset_done",   id, int'(act_done[id]),   0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_sweep(tbl[i].id, tbl[i].op, pat, nstb, lat, nmis);
      $display("sweep dut=%0d op=%0d strobes=%0d pattern=%02h latency=%0d mism=%0d",
               tbl[i].id, tbl[i].op, nstb, pat, lat, nmis);
      chk("tbl_pattern", tbl[i].id, int'(pat), int'(tbl[i].pat));
      chk("tbl_strobes", tbl[i].id, nstb, tbl[i].nstb);
      chk("tbl_latency", tbl[i].id, lat,  tbl[i].lat);
`ifdef GATE_SWEEP_CHECK_EN
      if (i == 0) begin
        chk("and_tied1_mismatch_pulses", 0, nmis, 3);
        chk("and_tied1_err_cnt", 0, act_err[0], 3);
      end
`endif
    end

`ifdef GATE_SWEEP_CHECK_EN
    dut_mode[1] = 1;
    run_sweep(1, 2, pat, nstb, lat, nmis);
    $display("sweep dut=1 op=2 inverted dut_out mism=%0d err=%0d", nmis, act_err[1]);
    chk("sat_mismatch_pulses", 1, nmis, 8);
    chk("sat_err_cnt", 1, act_err[1], 3);
    dut_mode[1] = 0;
`endif

    // NAND latched; op change and start during RUN, start during DONE.
    @(negedge clk);
    drv_op[0] = 3'd3;
    drv_start[0] = 1'b1;
    @(negedge clk);
    drv_start[0] = 1'b0;
    c = 1; pat = '0; nstb = 0; lat = -1;
    while (c < 200) begin
      if (c == 12) drv_op[0] = 3'd1;
      if (c == 20) drv_start[0] = 1'b1;
      if (c == 21) drv_start[0] = 1'b0;
      if (act_strobe[0]) begin
        if (nstb < 8) pat[nstb] = act_gate[0];
        nstb++;
      end
      if (act_done[0]) begin
        lat = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    $display("sweep dut=0 nand op-change pattern=%02h latency=%0d", pat, lat);
    chk("nand_latched_pattern", 0, int'(pat), 8'h07);
    chk("nand_latched_strobes", 0, nstb, 4);
    chk("nand_latched_latency", 0, lat, 41);
    drv_start[0] = 1'b1;
    @(negedge clk);
    drv_start[0] = 1'b0;
    chk("start_in_done_ignored", 0, int'(act_busy[0]), 0);

    // abort while vec=2
    @(negedge clk);
    drv_op[0] = 3'd0;
    drv_start[0] = 1'b1;
    @(negedge clk);
    drv_start[0] = 1'b0;
    c = 0;
    while ((act_vec[0] != 8'd2) && (c < 100)) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reach_vec2", 0, int'(c < 100), 1);
    repeat (3) @(negedge clk);
    drv_abort[0] = 1'b1;
    @(negedge clk);
    drv_abort[0] = 1'b0;
    chk("abort_busy",   0, int'(act_busy[0]),   0);
    chk("abort_vec",    0, int'(act_vec[0]),    2);
    chk("abort_done",   0, int'(act_done[0]),   0);
    chk("abort_strobe", 0, int'(act_strobe[0]), 0);
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (act_done[0]) ndone++;
    end
    chk("abort_no_done", 0, ndone, 0);
    $display("abort dut=0 at vec=2 done_after=%0d", ndone);

    // restart from 0, then abort on the final strobe (beats DONE)
    drv_start[0] = 1'b1;
    @(negedge clk);
    drv_start[0] = 1'b0;
    chk("restart_vec",  0, int'(act_vec[0]),  0);
    chk("restart_busy", 0, int'(act_busy[0]), 1);
    c = 0;
    while (!((act_vec[0] == 8'd3) && act_strobe[0]) && (c < 100)) begin
      @(negedge clk);
      c++;
    end
    chk("reach_last_strobe", 0, int'(c < 100), 1);
    drv_abort[0] = 1'b1;
    @(negedge clk);
    drv_abort[0] = 1'b0;
    chk("abort_last_busy", 0, int'(act_busy[0]), 0);
    chk("abort_last_done", 0, int'(act_done[0]), 0);
    chk("abort_last_vec",  0, int'(act_vec[0]),  3);
    $display("abort dut=0 on final strobe vec=%0d", act_vec[0]);

    // abort and start together in IDLE: stay idle
    drv_start[0] = 1'b1;
    drv_abort[0] = 1'b1;
    @(negedge clk);
    drv_start[0] = 1'b0;
    drv_abort[0] = 1'b0;
    chk("abort_start_idle_busy", 0, int'(act_busy[0]), 0);

    // reset mid-sweep on both instances
    drv_op[0] = 3'd3;
    drv_op[1] = 3'd4;
    drv_start[0] = 1'b1;
    drv_start[1] = 1'b1;
    @(negedge clk);
    drv_start[0] = 1'b0;
    drv_start[1] = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      chk("midrst_vec",    id, int'(act_vec[id]),    0);
      chk("midrst_gate",   id, int'(act_gate[id]),   0);
      chk("midrst_busy",   id, int'(act_busy[id]),   0);
      chk("midrst_strobe", id, int'(act_strobe[id]), 0);
      chk("midrst_done",   id, int'(act_done[id]),   0);
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (act_done[0] || act_done[1]) ndone++;
    end
    chk("midrst_no_done", 0, ndone, 0);
    $display("reset mid-sweep done_after=%0d", ndone);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      for (int id = 0; id < 2; id++) begin
        drv_start[id] = ($urandom_range(0, 7) == 0);
        drv_abort[id] = ($urandom_range(0, 59) == 0);
        drv_op[id]    = 3'($urandom_range(0, 7));
        if (!act_strobe[id] && !exp_strobe(id) && ($urandom_range(0, 15) == 0))
          dut_mode[id] = int'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int id = 0; id < 2; id++) begin
      drv_start[id] = 1'b0;
      drv_abort[id] = 1'b0;
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
